// File: rtl/spi_periph_pkg.sv
// Shared types and frame constants for the SPI-to-peripheral register bridge.
package spi_periph_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CMD_BITS   = 8;
    localparam int DATA_BITS  = 8;
    localparam int RW_BIT     = 7;
    localparam int FRAME_BITS = CMD_BITS + DATA_BITS;

endpackage

// File: rtl/spi_edge_detect.sv
// Registers the synchronized SPI clock and produces single-cycle rise/fall pulses.
module spi_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic spi_clk,
    output logic rise,
    output logic fall
);

    logic spi_clk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            spi_clk_q <= 1'b0;
        end else begin
            spi_clk_q <= spi_clk;
        end
    end

    assign rise = spi_clk & ~spi_clk_q;
    assign fall = ~spi_clk & spi_clk_q;

endmodule

// File: rtl/spi_periph_bridge.sv
// SPI mode-0 slave turning 16-bit command/data frames into peripheral register strobes.
// Optional feature: define SPI_BURST_EN for auto-incrementing multi-byte bursts.
module spi_periph_bridge
    import spi_periph_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_cs_n,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              reg_re,
    output logic              frame_err
);

    localparam logic [4:0] CNT_CMD_LAST   = 5'(CMD_BITS - 1);
    localparam logic [4:0] CNT_CMD        = 5'(CMD_BITS);
    localparam logic [4:0] CNT_FRAME_LAST = 5'(FRAME_BITS - 1);
    localparam logic [4:0] CNT_FRAME      = 5'(FRAME_BITS);
`ifdef SPI_BURST_EN
    localparam logic [4:0] CNT_BURST_LAST = 5'(FRAME_BITS + DATA_BITS - 1);
`endif

    state_t            state;
    logic [4:0]        bit_cnt;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_next;
    logic              rw;
    logic              load_pending;
    logic              inc_pending;
    logic              rise;
    logic              fall;
    logic              byte_last;
    logic              at_boundary;

    spi_edge_detect u_edge (
        .clk     (clk),
        .rst     (rst),
        .spi_clk (spi_clk),
        .rise    (rise),
        .fall    (fall)
    );

    assign rx_next = {rx_sr[DATA_W-2:0], spi_mosi};

    // The first fall after a byte boundary must not shift: the master has not sampled tx[7] yet.
    assign at_boundary = (bit_cnt == CNT_CMD) || (bit_cnt == CNT_FRAME);

`ifdef SPI_BURST_EN
    assign byte_last = (bit_cnt == CNT_FRAME_LAST) || (bit_cnt == CNT_BURST_LAST);
`else
    assign byte_last = (bit_cnt == CNT_FRAME_LAST);
`endif

    assign spi_miso = (state == DATA && !rw) ? tx_sr[DATA_W-1] : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= 5'd0;
            rx_sr        <= '0;
            tx_sr        <= '0;
            rw           <= 1'b0;
            load_pending <= 1'b0;
            inc_pending  <= 1'b0;
            reg_addr     <= '0;
            reg_wdata    <= '0;
            reg_we       <= 1'b0;
            reg_re       <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            frame_err <= 1'b0;

            // CS deassertion beats any coincident SPI clock edge and cancels pending strobes.
            if (spi_cs_n) begin
                if (state != IDLE && bit_cnt != 5'd0 && bit_cnt != CNT_FRAME) begin
                    frame_err <= 1'b1;
                end
                state        <= IDLE;
                bit_cnt      <= 5'd0;
                load_pending <= 1'b0;
                inc_pending  <= 1'b0;
            end else begin
                if (load_pending) begin
                    load_pending <= 1'b0;
                    if (!rw) begin
                        tx_sr  <= reg_rdata;
                        reg_re <= 1'b1;
                    end
                end
                if (inc_pending) begin
                    inc_pending  <= 1'b0;
                    reg_addr     <= reg_addr + ADDR_W'(1);
                    load_pending <= 1'b1;
                end

                case (state)
                    IDLE: begin
                        state   <= CMD;
                        bit_cnt <= 5'd0;
                    end
                    CMD: begin
                        if (rise) begin
                            rx_sr   <= rx_next;
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == CNT_CMD_LAST) begin
                                rw           <= rx_next[RW_BIT];
                                reg_addr     <= rx_next[ADDR_W-1:0];
                                load_pending <= 1'b1;
                                state        <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (rise) begin
                            rx_sr   <= rx_next;
                            bit_cnt <= bit_cnt + 5'd1;
                            if (byte_last) begin
                                if (rw) begin
                                    reg_we    <= 1'b1;
                                    reg_wdata <= rx_next;
                                end
`ifdef SPI_BURST_EN
                                bit_cnt     <= CNT_FRAME;
                                inc_pending <= 1'b1;
`else
                                state       <= DONE;
`endif
                            end
                        end else if (fall && !at_boundary && !rw) begin
                            tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                        end
                    end
                    DONE: begin
                        bit_cnt <= CNT_FRAME;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_periph_bridge.sv
// Self-checking bench for spi_periph_bridge: vector table, corner sequences, randomized frames.
module tb_spi_periph_bridge;

`ifdef SPI_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_cs_n;
    logic       spi_clk;
    logic       spi_mosi;
    logic       spi_miso;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       reg_we;
    logic       reg_re;
    logic       frame_err;

    logic [7:0] mem [16];
    assign reg_rdata = mem[reg_addr];

    int tests = 0;
    int fails = 0;

    logic [3:0] we_addr_q [$];
    logic [7:0] we_data_q [$];
    logic [3:0] exp_wa_q [$];
    logic [7:0] exp_wd_q [$];
    int         re_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] miso_byte;
    logic       miso_cmd_seen;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        int         nbits;
        logic [7:0] rdata;
        int         exp_we;
        logic [3:0] exp_addr;
        logic [7:0] exp_wdata;
        int         exp_re;
        int         exp_err;
        logic       chk_miso;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t vecs [$];

    always #5 clk = ~clk;

    spi_periph_bridge #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .spi_cs_n  (spi_cs_n),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_rdata (reg_rdata),
        .reg_re    (reg_re),
        .frame_err (frame_err)
    );

    // Strobe monitor: every high cycle counts, so a stretched pulse shows up as an extra event.
    always @(negedge clk) begin
        if (reg_we) begin
            we_addr_q.push_back(reg_addr);
            we_data_q.push_back(reg_wdata);
        end
        if (reg_re) re_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_monitor();
        we_addr_q.delete();
        we_data_q.delete();
        exp_wa_q.delete();
        exp_wd_q.delete();
        re_cnt        = 0;
        err_cnt       = 0;
        miso_byte     = 8'h00;
        miso_cmd_seen = 1'b0;
    endtask

    // Master side of mode 0: data set while SCK low, MISO sampled just before SCK rises.
    task automatic send_bits(input logic [31:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = frame[31-i];
            repeat (5) @(negedge clk);
            if (i < 8) miso_cmd_seen = miso_cmd_seen | spi_miso;
            else if (i < 16) miso_byte = {miso_byte[6:0], spi_miso};
            spi_clk = 1'b1;
            repeat (5) @(negedge clk);
            spi_clk = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] frame, input int nbits);
        spi_cs_n = 1'b0;
        repeat (3) @(negedge clk);
        send_bits(frame, nbits);
        repeat (3) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int nbits, input logic [3:0] exp_addr,
                               input int exp_re, input int exp_err,
                               input logic chk_miso, input logic [7:0] exp_miso);
        checkOutput({tag, " we_count"}, 32'(we_addr_q.size()), 32'(exp_wa_q.size()));
        for (int k = 0; k < exp_wa_q.size() && k < we_addr_q.size(); k++) begin
            checkOutput({tag, " we_addr"}, 32'(we_addr_q[k]), 32'(exp_wa_q[k]));
            checkOutput({tag, " we_data"}, 32'(we_data_q[k]), 32'(exp_wd_q[k]));
        end
        if (exp_wd_q.size() > 0)
            checkOutput({tag, " wdata_hold"}, 32'(reg_wdata), 32'(exp_wd_q[exp_wd_q.size()-1]));
        checkOutput({tag, " re_count"}, 32'(re_cnt), 32'(exp_re));
        checkOutput({tag, " frame_err"}, 32'(err_cnt), 32'(exp_err));
        if (nbits >= 8) checkOutput({tag, " reg_addr"}, 32'(reg_addr), 32'(exp_addr));
        checkOutput({tag, " miso_cmd_low"}, 32'(miso_cmd_seen), 32'(0));
        if (chk_miso) checkOutput({tag, " miso_byte"}, 32'(miso_byte), 32'(exp_miso));
    endtask

    initial begin
        rst      = 1'b1;
        spi_cs_n = 1'b1;
        spi_clk  = 1'b0;
        spi_mosi = 1'b0;
        for (int k = 0; k < 16; k++) mem[k] = 8'h00;

        // Vector table: cmd, data, nbits, rdata, we, addr, wdata, re, err, chk_miso, miso
        vecs.push_back('{8'h83, 8'h5A, 16, 8'h00, 1, 4'h3, 8'h5A, 0, 0, 1'b0, 8'h00});
        vecs.push_back('{8'h05, 8'h00, 16, 8'hC3, 0, 4'h5, 8'h00, 1, 0, 1'b1, 8'hC3});
        vecs.push_back('{8'h81, 8'h77, 11, 8'h00, 0, 4'h1, 8'h00, 0, 1, 1'b0, 8'h00});
        vecs.push_back('{8'h82, 8'h11, 20, 8'h00, 1, 4'h2, 8'h11, 0, 0, 1'b0, 8'h00});
        vecs.push_back('{8'hF6, 8'h99, 16, 8'h00, 1, 4'h6, 8'h99, 0, 0, 1'b0, 8'h00});
        vecs.push_back('{8'h07, 8'h00, 12, 8'h5E, 0, 4'h7, 8'h00, 1, 1, 1'b0, 8'h00});
        vecs.push_back('{8'h0C, 8'h00, 16, 8'h81, 0, 4'hC, 8'h00, 1, 0, 1'b1, 8'h81});
        vecs.push_back('{8'h8A, 8'h00,  5, 8'h00, 0, 4'h0, 8'h00, 0, 1, 1'b0, 8'h00});
        vecs.push_back('{8'h8A, 8'h3C, 16, 8'h00, 1, 4'hA, 8'h3C, 0, 0, 1'b0, 8'h00});
        vecs.push_back('{8'h00, 8'h00,  8, 8'hA5, 0, 4'h0, 8'h00, 1, 1, 1'b0, 8'h00});

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("reset reg_addr", 32'(reg_addr), 32'(0));
        checkOutput("reset reg_wdata", 32'(reg_wdata), 32'(0));
        checkOutput("reset strobes", 32'({reg_we, reg_re, frame_err}), 32'(0));
        checkOutput("reset miso", 32'(spi_miso), 32'(0));
        rst = 1'b0;
        repeat (3) @(negedge clk);

`ifndef SPI_BURST_EN
        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            for (int k = 0; k < 16; k++) mem[k] = 8'($urandom);
            mem[v.cmd[3:0]] = v.rdata;
            clear_monitor();
            if (v.exp_we > 0) begin
                exp_wa_q.push_back(v.exp_addr);
                exp_wd_q.push_back(v.exp_wdata);
            end
            applyStimulus({v.cmd, v.data, 16'hFFFF}, v.nbits);
            check_frame($sformatf("vec%0d", i), v.nbits, v.exp_addr, v.exp_re, v.exp_err,
                        v.chk_miso, v.exp_miso);
        end
`endif

        // Reset asserted part-way through a write frame
        clear_monitor();
        spi_cs_n = 1'b0;
        repeat (3) @(negedge clk);
        send_bits({8'h83, 8'h5A, 16'h0000}, 12);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid reg_addr", 32'(reg_addr), 32'(0));
        checkOutput("rst_mid reg_wdata", 32'(reg_wdata), 32'(0));
        checkOutput("rst_mid outputs", 32'({reg_we, reg_re, spi_miso, frame_err}), 32'(0));
        spi_cs_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("rst_mid no_we", 32'(we_addr_q.size()), 32'(0));
        checkOutput("rst_mid no_err", 32'(err_cnt), 32'(0));
        clear_monitor();
        exp_wa_q.push_back(4'h1);
        exp_wd_q.push_back(8'hFF);
        applyStimulus({8'h81, 8'hFF, 16'h0000}, 16);
        check_frame("after_rst", 16, 4'h1, 0, 0, 1'b0, 8'h00);

        // CS rise in the same clock as the 16th SCK rise: CS wins, byte never completes
        clear_monitor();
        spi_cs_n = 1'b0;
        repeat (3) @(negedge clk);
        send_bits({8'h84, 8'h33, 16'h0000}, 15);
        repeat (5) @(negedge clk);
        spi_clk  = 1'b1;
        spi_cs_n = 1'b1;
        repeat (5) @(negedge clk);
        spi_clk = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("cs_edge_race no_we", 32'(we_addr_q.size()), 32'(0));
        checkOutput("cs_edge_race frame_err", 32'(err_cnt), 32'(1));

`ifdef SPI_BURST_EN
        clear_monitor();
        exp_wa_q.push_back(4'hF);
        exp_wd_q.push_back(8'hAA);
        exp_wa_q.push_back(4'h0);
        exp_wd_q.push_back(8'hBB);
        applyStimulus({8'h8F, 8'hAA, 8'hBB, 8'h00}, 24);
        check_frame("burst_wrap", 24, 4'h1, 0, 0, 1'b0, 8'h00);
`endif

        // Randomized frames against a frame-level reference model
        for (int n = 0; n < 30; n++) begin
            logic [7:0]  cmd;
            logic [23:0] dat;
            logic [3:0]  a;
            int          nbits;
            int          nfull;
            int          exp_re;
            int          exp_err;
            cmd = 8'($urandom);
            dat = 24'($urandom);
            nbits = ($urandom_range(0, 9) < 6) ? 16 : int'($urandom_range(1, 24));
            for (int k = 0; k < 16; k++) mem[k] = 8'($urandom);
            a = cmd[3:0];
            clear_monitor();
            nfull = (nbits < 16) ? 0 : (BURST ? (nbits - 8) / 8 : 1);
            if (cmd[7]) begin
                for (int k = 0; k < nfull; k++) begin
                    exp_wa_q.push_back(a + 4'(k));
                    exp_wd_q.push_back(dat[23 - 8*k -: 8]);
                end
            end
            exp_re  = (!cmd[7] && nbits >= 8) ? (BURST ? 1 + nfull : 1) : 0;
            exp_err = ((nbits > 0 && nbits < 16) || (BURST && nbits > 16 && (nbits % 8) != 0)) ? 1 : 0;
            applyStimulus({cmd, dat}, nbits);
            check_frame($sformatf("rand%0d", n), nbits, a + (BURST ? 4'(nfull) : 4'd0),
                        exp_re, exp_err, (!cmd[7] && nbits >= 16), mem[a]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
